// File: rtl/fft_reorder_buffer.sv
// Bit-reversal reorder buffer: ping-pong banks turn the SDF FFT's bit-reversed stream into natural bin order.
// Latency 2 cycles from last input sample to bin 0; no backpressure, input spacing keeps banks from colliding.
module fft_reorder_buffer #(
  parameter int N = 64,
  parameter int WIDTH = 16,
  parameter bit OUT_HALF = 1'b0,
  localparam int LOG_N = $clog2(N)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             di_en,
  input  logic [WIDTH-1:0] di_re,
  input  logic [WIDTH-1:0] di_im,
  output logic             do_en,
  output logic [WIDTH-1:0] do_re,
  output logic [WIDTH-1:0] do_im,
  output logic [LOG_N-1:0] do_idx,
  output logic             do_last
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_READ = 1'b1;

  localparam logic [LOG_N-1:0] WR_LAST  = LOG_N'(N - 1);
  localparam logic [LOG_N-1:0] RD_FINAL = OUT_HALF ? LOG_N'(N / 2 - 1) : LOG_N'(N - 1);

  // Both banks share one array; the MSB of the address selects the bank.
  logic [2*WIDTH-1:0] r_mem [0:2*N-1];

  logic [LOG_N-1:0]   r_wr_cnt;
  logic               r_wr_bank;
  logic [0:0]         r_state;
  logic [LOG_N-1:0]   r_rd_cnt;
  logic               r_rd_bank;
  logic               r_rd_vld;
  logic [LOG_N-1:0]   r_rd_idx;
  logic               r_rd_last;
  logic [2*WIDTH-1:0] r_rd_dat;

  logic               w_frame_done;
  logic               w_rd_final;
  logic [LOG_N-1:0]   w_wr_addr;

  function automatic logic [LOG_N-1:0] bitrev(input logic [LOG_N-1:0] v);
    logic [LOG_N-1:0] rev;
    for (int i = 0; i < LOG_N; i++) begin
      rev[i] = v[LOG_N-1-i];
    end
    return rev;
  endfunction

  assign w_wr_addr    = bitrev(r_wr_cnt);
  assign w_frame_done = di_en && (r_wr_cnt == WR_LAST);
  assign w_rd_final   = (r_rd_cnt == RD_FINAL);

  // Write counter wraps naturally at N, so a frame boundary needs no extra compare.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_cnt  <= '0;
      r_wr_bank <= 1'b0;
    end else if (di_en) begin
      r_wr_cnt <= r_wr_cnt + LOG_N'(1);
      if (w_frame_done) begin
        r_wr_bank <= ~r_wr_bank;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (di_en && !reset) begin
      r_mem[{r_wr_bank, w_wr_addr}] <= {di_re, di_im};
    end
    r_rd_dat <= r_mem[{r_rd_bank, r_rd_cnt}];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_rd_cnt  <= '0;
      r_rd_bank <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_frame_done) begin
            r_state   <= S_READ;
            r_rd_cnt  <= '0;
            r_rd_bank <= r_wr_bank;
          end
        end
        S_READ: begin
          if (w_rd_final) begin
            // A completion on the final count chains straight into the next frame.
            if (w_frame_done) begin
              r_rd_cnt  <= '0;
              r_rd_bank <= r_wr_bank;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_rd_cnt <= r_rd_cnt + LOG_N'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_rd_vld  <= 1'b0;
      r_rd_idx  <= '0;
      r_rd_last <= 1'b0;
    end else begin
      r_rd_vld  <= (r_state == S_READ);
      r_rd_idx  <= r_rd_cnt;
      r_rd_last <= (r_state == S_READ) && w_rd_final;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      do_en   <= 1'b0;
      do_re   <= '0;
      do_im   <= '0;
      do_idx  <= '0;
      do_last <= 1'b0;
    end else begin
      do_en   <= r_rd_vld;
      do_re   <= r_rd_vld ? r_rd_dat[2*WIDTH-1:WIDTH] : '0;
      do_im   <= r_rd_vld ? r_rd_dat[WIDTH-1:0] : '0;
      do_idx  <= r_rd_vld ? r_rd_idx : '0;
      do_last <= r_rd_vld && r_rd_last;
    end
  end

`ifndef SYNTHESIS
  a_no_overlap: assert property (@(posedge clock) disable iff (reset)
    !(w_frame_done && (r_state == S_READ) && !w_rd_final));
`endif

endmodule

// File: tb/tb_fft_reorder_buffer.sv
// Bench for fft_reorder_buffer: N=64 full-spectrum and N=16 half-spectrum instances against a
// frame-level reference model, plus table vectors and hand-written reset/latency sequences.
module tb_fft_reorder_buffer;

  typedef struct {
    int          cyc;
    int          idx;
    logic [15:0] re;
    logic [15:0] im;
    bit          last;
  } obs_t;

  typedef struct {
    int d;
    int k;
    int re;
    bit last;
  } vec_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        a_en = 1'b0, b_en = 1'b0;
  logic [15:0] a_re = '0, a_im = '0, b_re = '0, b_im = '0;
  logic        a_oen, a_olast, b_oen, b_olast;
  logic [15:0] a_ore, a_oim, b_ore, b_oim;
  logic [5:0]  a_oidx;
  logic [3:0]  b_oidx;

  int errs = 0;
  int chks = 0;
  int tnow = 0;
  int last_wr = 0;

  logic [31:0] part [2][$];
  obs_t        expq [2][$];
  obs_t        cap0[$], cap1[$], ref0[$];

  fft_reorder_buffer #(.N(64), .WIDTH(16), .OUT_HALF(1'b0)) u_a (
    .clock(clock), .reset(reset), .di_en(a_en), .di_re(a_re), .di_im(a_im),
    .do_en(a_oen), .do_re(a_ore), .do_im(a_oim), .do_idx(a_oidx), .do_last(a_olast));

  fft_reorder_buffer #(.N(16), .WIDTH(16), .OUT_HALF(1'b1)) u_b (
    .clock(clock), .reset(reset), .di_en(b_en), .di_re(b_re), .di_im(b_im),
    .do_en(b_oen), .do_re(b_ore), .do_im(b_oim), .do_idx(b_oidx), .do_last(b_olast));

  always #5 clock = ~clock;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    chks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int rev(input int v, input int n);
    int r = 0;
    int x = v;
    for (int m = 1; m < n; m = m * 2) begin
      r = r * 2 + x % 2;
      x = x / 2;
    end
    return r;
  endfunction

  // Reference: a frame of n samples becomes k bins, bin b holding stream sample rev(b), shown at t+2+b.
  task automatic step(input int d, input int n, input int k, input int t, input logic rst,
                      input logic en, input logic [15:0] re, input logic [15:0] im,
                      input logic oen, input logic [15:0] ore, input logic [15:0] oim,
                      input int oidx, input logic olast);
    obs_t e;
    if (rst) begin
      part[d].delete();
      expq[d].delete();
    end else if (en) begin
      part[d].push_back({re, im});
      if (part[d].size() == n) begin
        for (int b = 0; b < k; b++) begin
          e.cyc = t + 2 + b;
          e.idx = b;
          {e.re, e.im} = part[d][rev(b, n)];
          e.last = (b == k - 1);
          expq[d].push_back(e);
        end
        part[d].delete();
      end
    end
    if (expq[d].size() > 0 && expq[d][0].cyc == t) begin
      e = expq[d].pop_front();
      check($sformatf("dut%0d_bin_t%0d", d, t), {22'd0, oen, olast, 8'(oidx), ore, oim},
            {22'd0, 1'b1, e.last, 8'(e.idx), e.re, e.im});
    end else begin
      check($sformatf("dut%0d_idle_t%0d", d, t), {30'd0, oen, olast, ore, oim}, 64'd0);
    end
  endtask

  initial begin
    obs_t o;
    forever begin
      @(posedge clock);
      tnow++;
      #1;
      step(0, 64, 64, tnow, reset, a_en, a_re, a_im, a_oen, a_ore, a_oim, int'(a_oidx), a_olast);
      step(1, 16, 8, tnow, reset, b_en, b_re, b_im, b_oen, b_ore, b_oim, int'(b_oidx), b_olast);
      if (a_oen) begin
        o.cyc = tnow; o.idx = int'(a_oidx); o.re = a_ore; o.im = a_oim; o.last = a_olast;
        cap0.push_back(o);
      end
      if (b_oen) begin
        o.cyc = tnow; o.idx = int'(b_oidx); o.re = b_ore; o.im = b_oim; o.last = b_olast;
        cap1.push_back(o);
      end
    end
  end

  task automatic drv(input int d, input logic [15:0] re, input logic [15:0] im);
    @(negedge clock);
    a_en = (d == 0);
    b_en = (d == 1);
    a_re = re; a_im = im;
    b_re = re; b_im = im;
    last_wr = tnow + 1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clock);
      a_en = 1'b0;
      b_en = 1'b0;
    end
  endtask

  // mode 0: re=base+p, im=-re; mode 1: random data. gaps!=0 inserts random 1-5 cycle holes.
  task automatic frame(input int d, input int n, input int mode, input int base, input int gaps);
    for (int p = 0; p < n; p++) begin
      logic [15:0] v;
      if (gaps != 0 && $urandom_range(0, 3) == 0) idle($urandom_range(1, 5));
      v = (mode == 0) ? 16'(base + p) : 16'($urandom);
      drv(d, v, (mode == 0) ? 16'(-v) : 16'($urandom));
    end
  endtask

  initial begin
    vec_t tbl[18];
    obs_t q;
    int   n0;
    int   bad;

    tbl[0]  = '{0, 0, 0, 0};   tbl[1]  = '{0, 1, 32, 0};  tbl[2]  = '{0, 2, 16, 0};
    tbl[3]  = '{0, 3, 48, 0};  tbl[4]  = '{0, 4, 8, 0};   tbl[5]  = '{0, 5, 40, 0};
    tbl[6]  = '{0, 6, 24, 0};  tbl[7]  = '{0, 7, 56, 0};  tbl[8]  = '{0, 62, 31, 0};
    tbl[9]  = '{0, 63, 63, 1};
    tbl[10] = '{1, 0, 0, 0};   tbl[11] = '{1, 1, 8, 0};   tbl[12] = '{1, 2, 4, 0};
    tbl[13] = '{1, 3, 12, 0};  tbl[14] = '{1, 4, 2, 0};   tbl[15] = '{1, 5, 10, 0};
    tbl[16] = '{1, 6, 6, 0};   tbl[17] = '{1, 7, 14, 1};

    repeat (3) @(negedge clock);
    reset = 1'b0;
    idle(2);
    check("idle_after_reset", {60'd0, a_oen, a_olast, b_oen, b_olast}, 64'd0);
    check("idle_data_after_reset", {32'd0, a_ore | a_oim, b_ore | b_oim}, 64'd0);

    // Ramp on the full-spectrum instance
    cap0.delete();
    frame(0, 64, 0, 0, 0);
    idle(70);
    check("ramp64_count", 64'(cap0.size()), 64'd64);
    if (cap0.size() > 0) check("ramp64_latency", 64'(cap0[0].cyc - last_wr + 64 - 1), 64'd2 + 63);
    ref0 = cap0;
    check("idle_between_frames", {62'd0, a_oen, a_olast}, 64'd0);

    // Ramp on the half-spectrum instance
    cap1.delete();
    frame(1, 16, 0, 0, 0);
    idle(30);
    check("ramp16h_count", 64'(cap1.size()), 64'd8);
    if (cap1.size() > 0) check("ramp16h_latency", 64'(cap1[0].cyc - last_wr), 64'd2);

    for (int i = 0; i < 18; i++) begin
      if (tbl[i].d == 0 && tbl[i].k < ref0.size()) q = ref0[tbl[i].k];
      else if (tbl[i].d == 1 && tbl[i].k < cap1.size()) q = cap1[tbl[i].k];
      else q = '{0, -1, 16'hdead, 16'hdead, 1'b0};
      check($sformatf("table_%0d", i), {22'd0, 8'(q.idx), q.re, q.im, 1'b0, q.last},
            {22'd0, 8'(tbl[i].k), 16'(tbl[i].re), 16'(-tbl[i].re), 1'b0, tbl[i].last});
    end

    // Three back-to-back frames must stream without a gap
    cap0.delete();
    for (int f = 0; f < 3; f++) frame(0, 64, 0, 100 * f, 0);
    idle(80);
    check("b2b_count", 64'(cap0.size()), 64'd192);
    if (cap0.size() == 192) begin
      check("b2b_span", 64'(cap0[191].cyc - cap0[0].cyc), 64'd191);
      check("b2b_wrap", {48'd0, 8'(cap0[63].idx), 8'(cap0[64].idx)}, {48'd0, 8'd63, 8'd0});
      check("b2b_f2_bin1", 64'(cap0[129].re), 64'd232);
    end

    // Gapped ramp must match the gap-free output
    cap0.delete();
    frame(0, 64, 0, 0, 1);
    idle(70);
    check("gap_count", 64'(cap0.size()), 64'd64);
    if (cap0.size() == 64) begin
      check("gap_latency", 64'(cap0[0].cyc - last_wr), 64'd2);
      bad = 0;
      for (int k = 0; k < 64; k++)
        if (cap0[k].re !== ref0[k].re || cap0[k].im !== ref0[k].im || cap0[k].idx != ref0[k].idx) bad++;
      check("gap_vs_gapfree", 64'(bad), 64'd0);
    end

    // Reset part-way through a frame discards it
    cap0.delete();
    frame(0, 20, 0, 700, 0);
    @(negedge clock);
    reset = 1'b1;
    a_en = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    frame(0, 64, 0, 500, 0);
    idle(70);
    check("rst_partial_count", 64'(cap0.size()), 64'd64);
    if (cap0.size() == 64) check("rst_partial_bins", {32'(cap0[0].re), 32'(cap0[1].re)}, {32'd500, 32'd532});

    // Reset during READ stops the frame on the next edge
    cap0.delete();
    frame(0, 64, 1, 0, 0);
    idle(12);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("rst_read_outputs", {29'd0, a_oen, a_olast, a_oidx != 6'd0, a_ore, a_oim}, 64'd0);
    n0 = cap0.size();
    @(negedge clock);
    reset = 1'b0;
    idle(80);
    check("rst_read_no_more", 64'(cap0.size()), 64'(n0));
    check("rst_read_partial", 64'(n0 >= 5 && n0 <= 20), 64'd1);

    // Random traffic on both instances, checked cycle by cycle by the model
    cap1.delete();
    for (int f = 0; f < 3; f++) frame(1, 16, 1, 0, f);
    idle(40);
    check("rand16h_count", 64'(cap1.size()), 64'd24);
    cap0.delete();
    for (int f = 0; f < 4; f++) frame(0, 64, 1, 0, 1);
    idle(80);
    check("rand64_count", 64'(cap0.size()), 64'd256);

    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end

endmodule
